// File: rtl/crc16_pkg.sv
// -----------------------------------------------------------------------------
// crc16_pkg
// Shared definitions for the transmit-side CRC-16 sequencer and its serial
// engine: polynomial, seed, data/CRC widths, the sequencer state encoding and
// the single-bit CRC update used by the engine.
// -----------------------------------------------------------------------------
package crc16_pkg;

  localparam int BYTE_W = 8;
  localparam int CRC_W  = 16;

  localparam logic [CRC_W-1:0] CRC16_POLY = 16'h8005;
  localparam logic [CRC_W-1:0] CRC16_SEED = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CLEAR      = 3'd1,
    ST_LOAD       = 3'd2,
    ST_SHIFT_DATA = 3'd3,
    ST_LATCH      = 3'd4,
    ST_SHIFT_CRC  = 3'd5,
    ST_DONE       = 3'd6
  } tx_seq_state_t;

  // One serial step of the MSB-first LFSR: the feedback tap is the outgoing
  // MSB xored with the incoming bit.
  function automatic logic [CRC_W-1:0] crc16_step(input logic [CRC_W-1:0] q,
                                                  input logic             bit_in);
    logic w_test;
    w_test = q[CRC_W-1] ^ bit_in;
    return {q[CRC_W-2:0], 1'b0} ^ (w_test ? CRC16_POLY : '0);
  endfunction

endpackage

// File: rtl/crc16_tx_sequencer_if.sv
// -----------------------------------------------------------------------------
// crc16_tx_sequencer_if
// Handshake bundle between the packet buffer / bit encoder and the sequencer.
//   start       : one-cycle packet request
//   data_in     : payload byte
//   data_valid  : data_in valid
//   data_last   : data_in is the final payload byte
//   data_ready  : byte accepted on data_valid && data_ready
//   tx_bit      : current serial bit
//   tx_valid    : tx_bit valid
//   tx_ready    : bit consumed on tx_valid && tx_ready
//   tx_crc      : tx_bit is a CRC bit
//   busy        : sequencer not idle
//   done        : one-cycle pulse after the last CRC bit
// slave modport is the sequencer side, master is the surrounding transmit path.
// -----------------------------------------------------------------------------
interface crc16_tx_sequencer_if;
  import crc16_pkg::*;

  logic              start;
  logic [BYTE_W-1:0] data_in;
  logic              data_valid;
  logic              data_last;
  logic              data_ready;
  logic              tx_bit;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_crc;
  logic              busy;
  logic              done;

  modport master (
    output start, data_in, data_valid, data_last, tx_ready,
    input  data_ready, tx_bit, tx_valid, tx_crc, busy, done
  );

  modport slave (
    input  start, data_in, data_valid, data_last, tx_ready,
    output data_ready, tx_bit, tx_valid, tx_crc, busy, done
  );

endinterface

// File: rtl/crc16_serial.sv
// -----------------------------------------------------------------------------
// crc16_serial
// Bit-serial CRC-16 engine (poly 0x8005, seed 0x0000, inverted output).
//   i_clk       : system clock, rising edge
//   i_rst       : asynchronous active-high reset, loads the seed
//   i_clear     : synchronous reload of the seed
//   i_serial_in : next message bit
//   i_shift_en  : advance the LFSR by one bit
//   o_crc       : ~Q, taken straight from the state register
// -----------------------------------------------------------------------------
module crc16_serial
  import crc16_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_serial_in,
  input  logic             i_shift_en,
  output logic [CRC_W-1:0] o_crc
);

  logic [CRC_W-1:0] r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= CRC16_SEED;
    end else if (i_clear) begin
      r_q <= CRC16_SEED;
    end else if (i_shift_en) begin
      r_q <= crc16_step(r_q, i_serial_in);
    end
  end

  assign o_crc = ~r_q;

endmodule

// File: rtl/crc16_tx_sequencer.sv
// -----------------------------------------------------------------------------
// crc16_tx_sequencer
// Takes payload bytes over a valid/ready handshake, serialises them LSB-first
// onto a bit stream, feeds each transmitted data bit to the serial CRC engine
// and then appends the 16 CRC bits MSB-first.
//   i_clk : system clock, rising edge
//   i_rst : asynchronous active-high reset
//   bus   : crc16_tx_sequencer_if.slave (byte input, bit output, status)
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   IDLE        | waiting for start
//   CLEAR       | reload engine seed (one cycle)
//   LOAD        | data_ready=1, wait for next payload byte
//   SHIFT_DATA  | send byte LSB-first, engine shifts on each bit handshake
//   LATCH       | capture engine crc into the CRC shift register
//   SHIFT_CRC   | send 16 CRC bits MSB-first, engine frozen
//   DONE        | one-cycle done pulse
// -----------------------------------------------------------------------------
module crc16_tx_sequencer
  import crc16_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  crc16_tx_sequencer_if.slave   bus
);

  tx_seq_state_t     r_state;
  tx_seq_state_t     w_state_nxt;

  logic [BYTE_W-1:0] r_byte;
  logic              r_last;
  logic [CRC_W-1:0]  r_crc;
  // Low 3 bits count data bits, all 4 count CRC bits; cleared on phase entry.
  logic [3:0]        r_cnt;

  logic              w_clear;
  logic              w_shift_en;
  logic [CRC_W-1:0]  w_crc;

  logic              w_data_ready;
  logic              w_tx_valid;
  logic              w_tx_bit;
  logic              w_tx_crc;
  logic              w_done;

  logic              w_byte_hs;
  logic              w_bit_hs;

  assign w_byte_hs = (r_state == ST_LOAD) && bus.data_valid;
  assign w_bit_hs  = w_tx_valid && bus.tx_ready;

  // Engine advances only on data-bit handshakes.
  assign w_shift_en = (r_state == ST_SHIFT_DATA) && bus.tx_ready;

  crc16_serial u_crc16_serial (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (w_clear),
    .i_serial_in (r_byte[0]),
    .i_shift_en  (w_shift_en),
    .o_crc       (w_crc)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_clear      = 1'b0;
    w_data_ready = 1'b0;
    w_tx_valid   = 1'b0;
    w_tx_bit     = 1'b0;
    w_tx_crc     = 1'b0;
    w_done       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        w_clear     = 1'b1;
        w_state_nxt = ST_LOAD;
      end

      ST_LOAD: begin
        w_data_ready = 1'b1;
        if (bus.data_valid) begin
          w_state_nxt = ST_SHIFT_DATA;
        end
      end

      ST_SHIFT_DATA: begin
        w_tx_valid = 1'b1;
        w_tx_bit   = r_byte[0];
        if (bus.tx_ready && (r_cnt[2:0] == 3'd7)) begin
          w_state_nxt = r_last ? ST_LATCH : ST_LOAD;
        end
      end

      ST_LATCH: begin
        w_state_nxt = ST_SHIFT_CRC;
      end

      ST_SHIFT_CRC: begin
        w_tx_valid = 1'b1;
        w_tx_crc   = 1'b1;
        w_tx_bit   = r_crc[CRC_W-1];
        if (bus.tx_ready && (r_cnt == 4'd15)) begin
          w_state_nxt = ST_DONE;
        end
      end

      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_byte <= '0;
      r_last <= 1'b0;
      r_crc  <= '0;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_byte_hs) begin
            r_byte <= bus.data_in;
            r_last <= bus.data_last;
            r_cnt  <= '0;
          end
        end

        ST_SHIFT_DATA: begin
          if (w_bit_hs) begin
            r_byte <= {1'b0, r_byte[BYTE_W-1:1]};
            r_cnt  <= {1'b0, r_cnt[2:0] + 3'd1};
          end
        end

        ST_LATCH: begin
          r_crc <= w_crc;
          r_cnt <= '0;
        end

        ST_SHIFT_CRC: begin
          if (w_bit_hs) begin
            r_crc <= {r_crc[CRC_W-2:0], 1'b0};
            r_cnt <= r_cnt + 4'd1;
          end
        end

        default: begin
        end
      endcase
    end
  end

  assign bus.data_ready = w_data_ready;
  assign bus.tx_valid   = w_tx_valid;
  assign bus.tx_bit     = w_tx_bit;
  assign bus.tx_crc     = w_tx_crc;
  assign bus.done       = w_done;
  assign bus.busy       = (r_state != ST_IDLE);

endmodule

// File: doc/crc16_tx_sequencer.md
# crc16_tx_sequencer

Transmit-side sequencer for the serial CRC-16 engine (polynomial 0x8005, seed 0x0000, inverted output). It accepts packet payload bytes over a valid/ready handshake and serialises them LSB-first onto a bit stream with its own handshake. In step with that stream it drives the engine's clear and shift controls, then appends the 16 CRC bits MSB-first. It sits between the packet buffer and the bit-level encoder of the transmit path.

## Interface
- No parameters; the polynomial, seed and widths are fixed by the shared package.
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request to begin a packet; honoured only in IDLE
- data_in  in  8  payload byte
- data_valid  in  1  data_in is valid
- data_last  in  1  qualifies data_in as the final payload byte
- data_ready  out  1  byte accepted on data_valid && data_ready
- tx_bit  out  1  current serial bit
- tx_valid  out  1  tx_bit is valid
- tx_ready  in  1  bit consumed on tx_valid && tx_ready
- tx_crc  out  1  high while tx_bit is a CRC bit
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last CRC bit is consumed

## Operation
- FSM states and transitions:
  - IDLE: goes to CLEAR on start.
  - CLEAR: asserts the engine clear for one cycle, then goes to LOAD.
  - LOAD: data_ready=1. On byte acceptance, loads the 8-bit shifter, latches data_last, resets the bit counter, then goes to SHIFT_DATA.
  - SHIFT_DATA: tx_valid=1 and tx_bit=shifter[0]. Each bit handshake shifts the shifter right, pulses the engine shift_en with serial_in=tx_bit, and increments the counter. On the 8th handshake, goes to LATCH if last is latched, else to LOAD.
  - LATCH: captures the engine crc output (already ~Q) into a 16-bit register; tx_valid=0.
  - SHIFT_CRC: tx_valid=1, tx_crc=1, tx_bit=crc_reg[15]. Each handshake shifts left. On the 16th handshake, goes to DONE.
  - DONE: done=1 for one cycle, then goes to IDLE.
- The engine shifts only on data-bit handshakes, never during CRC bits.
- tx_ready low stalls the sequencer. tx_bit, the counter and the engine state hold until the handshake.
- data_valid low in LOAD: the sequencer waits indefinitely with tx_valid=0.
- start outside IDLE is ignored and is not queued.
- A packet always carries at least one byte; there is no empty-packet path.

## Timing
- Reset: state=IDLE and shifters, counters and the engine clear. All outputs are 0: data_ready, tx_bit, tx_valid, tx_crc, busy, done.
- Reset mid-packet aborts immediately to IDLE. No done pulse is issued, and the next packet starts from seed 0x0000.
- Latency: start at cycle T puts the FSM in CLEAR at T+1 and in LOAD at T+2 with data_ready=1. A byte accepted at T+2 gives the first tx_valid at T+3.
- With tx_ready held high:
  - Each byte costs 8 cycles of SHIFT_DATA plus 1 cycle of LOAD.
  - The final byte is followed by 1 LATCH cycle, 16 SHIFT_CRC cycles and 1 DONE cycle.
- The engine output is registered. crc is valid in LATCH, the cycle after the 8th bit handshake of the last byte.
- The bit counter is 3 bits in the data phase (wraps at 8) and 4 bits in the CRC phase (wraps at 16). The phase change is driven by the FSM, not by counter overflow.

## Structure
- Package crc16_pkg:
  - CRC16_POLY=16'h8005 and CRC16_SEED=16'h0000
  - the state enum tx_seq_state_t
  - widths BYTE_W=8 and CRC_W=16
- Sub-module crc16_serial: the serial engine, with ports clk, rst, clear, serial_in, shift_en, crc[15:0].
  - One step: test=Q[15]^serial_in; Q <= (Q<<1) ^ (test ? POLY : 0).
  - crc = ~Q.
- The top level holds the FSM, the byte shifter, the CRC shift register and the counter.

## Test plan
- Single byte 0x00, last=1, tx_ready=1: tx bits 0×8, then CRC 0xFFFF (16 ones, tx_crc=1); done pulses once, 28 cycles after start.
- Single byte 0x01, last=1: data bits 1,0,0,0,0,0,0,0, then CRC 0x7CFC sent MSB-first (0111 1100 1111 1100).
- Two bytes 0x01,0x00 with data_valid gapped 5 cycles: tx_valid stays low during the gap; CRC matches the golden bit-serial model.
- tx_ready toggled pseudo-randomly: tx_bit stable while stalled; bit stream and CRC identical to the unstalled run.
- start pulsed while busy: ignored; only one done pulse per packet.
- rst asserted in SHIFT_CRC: all outputs 0 that cycle; a following 0x00 packet yields CRC 0xFFFF.
